// File: rtl/work_pkg.sv
// Shared VGA timing defaults (640x480 @ 60 Hz) and the position type used by
// the sync generator.
package work_pkg;

  localparam int POS_W = 10;
  typedef logic [POS_W-1:0] pos_t;

  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;
  localparam bit DEF_SYNC_POL  = 1'b0;
  localparam int DEF_DIV       = 2;

  // Drive the sync level: 'pol' while active, its complement otherwise.
  function automatic logic sync_level(input logic active, input logic pol);
    return active ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_hvsync_gen_if.sv
// Timing outputs of the VGA sync generator; master drives, slave consumes.
interface vga_hvsync_gen_if;
  import work_pkg::*;

  logic        pix_en;
  pos_t        hpos;
  pos_t        vpos;
  logic        hsync;
  logic        vsync;
  logic        display_on;
  logic        line_end;
  logic        frame_end;
  logic [15:0] frame_cnt;

  modport master (
    output pix_en, hpos, vpos, hsync, vsync, display_on,
           line_end, frame_end, frame_cnt
  );

  modport slave (
    input pix_en, hpos, vpos, hsync, vsync, display_on,
          line_end, frame_end, frame_cnt
  );

endinterface

// File: rtl/pix_en_gen.sv
// Pixel clock-enable divider: one-clk pulse every DIV clk cycles, low in reset.
module pix_en_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic reset,
  output logic pix_en
);

  generate
    if (DIV <= 1) begin : g_nodiv
      logic unused_clk;
      assign unused_clk = clk;
      assign pix_en     = ~reset;
    end else begin : g_div
      localparam int            CW   = $clog2(DIV);
      localparam logic [CW-1:0] LAST = CW'(DIV - 1);

      logic [CW-1:0] div_cnt_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          div_cnt_reg <= '0;
        end else if (div_cnt_reg == LAST) begin
          div_cnt_reg <= '0;
        end else begin
          div_cnt_reg <= div_cnt_reg + 1'b1;
        end
      end

      assign pix_en = (div_cnt_reg == LAST) & ~reset;
    end
  endgenerate

endmodule

// File: rtl/vga_hvsync_gen.sv
// VGA horizontal/vertical sync and position generator.
// Define VGA_HVSYNC_FRAME_CNT_EN to build the completed-frame counter.
module vga_hvsync_gen
  import work_pkg::*;
#(
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter bit SYNC_POL  = DEF_SYNC_POL,
  parameter int DIV       = DEF_DIV
) (
  input  logic             clk,
  input  logic             reset,
  vga_hvsync_gen_if.master vga
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam pos_t H_LAST   = pos_t'(H_TOTAL - 1);
  localparam pos_t V_LAST   = pos_t'(V_TOTAL - 1);
  localparam pos_t H_VIS    = pos_t'(H_DISPLAY);
  localparam pos_t V_VIS    = pos_t'(V_DISPLAY);
  localparam pos_t HS_FIRST = pos_t'(H_DISPLAY + H_FRONT);
  localparam pos_t HS_LAST  = pos_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam pos_t VS_FIRST = pos_t'(V_DISPLAY + V_FRONT);
  localparam pos_t VS_LAST  = pos_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic pix_en;
  pos_t hpos_reg;
  pos_t vpos_reg;
  logic line_end;
  logic frame_end;
  logic hs_active;
  logic vs_active;

  pix_en_gen #(
    .DIV(DIV)
  ) u_pix_en_gen (
    .clk   (clk),
    .reset (reset),
    .pix_en(pix_en)
  );

  assign line_end  = pix_en & (hpos_reg == H_LAST);
  assign frame_end = line_end & (vpos_reg == V_LAST);

  // Reset wins over pix_en so a mid-frame reset restarts at pixel (0,0).
  always_ff @(posedge clk) begin
    if (reset) begin
      hpos_reg <= '0;
      vpos_reg <= '0;
    end else if (pix_en) begin
      if (hpos_reg == H_LAST) begin
        hpos_reg <= '0;
        vpos_reg <= (vpos_reg == V_LAST) ? '0 : vpos_reg + 1'b1;
      end else begin
        hpos_reg <= hpos_reg + 1'b1;
      end
    end
  end

  assign hs_active = ~reset & (hpos_reg >= HS_FIRST) & (hpos_reg <= HS_LAST);
  assign vs_active = ~reset & (vpos_reg >= VS_FIRST) & (vpos_reg <= VS_LAST);

  assign vga.pix_en     = pix_en;
  assign vga.hpos       = hpos_reg;
  assign vga.vpos       = vpos_reg;
  assign vga.hsync      = sync_level(hs_active, SYNC_POL);
  assign vga.vsync      = sync_level(vs_active, SYNC_POL);
  assign vga.display_on = ~reset & (hpos_reg < H_VIS) & (vpos_reg < V_VIS);
  assign vga.line_end   = line_end;
  assign vga.frame_end  = frame_end;

`ifdef VGA_HVSYNC_FRAME_CNT_EN
  logic [15:0] frame_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_reg <= '0;
    end else if (frame_end) begin
      frame_cnt_reg <= frame_cnt_reg + 16'd1;
    end
  end

  assign vga.frame_cnt = frame_cnt_reg;
`else
  assign vga.frame_cnt = '0;
`endif

endmodule
